// File: rtl/vram_writer.sv
// rtl/vram_writer.sv - buffered VRAM write port with hardware screen clear
module vram_writer #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CLEAR_BASE = 0,
  parameter int CLEAR_LEN  = 2000,
  parameter int BLANK_ONLY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_WIDTH-1:0]         req_address,
  input  logic [DATA_WIDTH-1:0]         req_data,
  input  logic                          clear_start,
  input  logic [DATA_WIDTH-1:0]         clear_data,
  input  logic                          video_enable,
  output logic                          w_enable,
  output logic [ADDR_WIDTH-1:0]         w_address,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CLR_W = $clog2(CLEAR_LEN) + 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_LEN - 1);

  typedef enum logic [1:0] {IDLE, WAIT_DRAIN, CLEAR} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   mem_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [CLR_W-1:0]        clr_cnt;
  logic [DATA_WIDTH-1:0]   fill;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic                    allow, empty, full, push, pop, clr_wr;

  // Writes are permitted either always or only while the display is blanked.
  assign allow    = (BLANK_ONLY == 0) || !video_enable;
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign push     = req_valid && req_ready;
  assign clr_addr = ADDR_WIDTH'(CLEAR_BASE) + ADDR_WIDTH'(clr_cnt);
  assign fifo_count = count;
  assign busy     = (state != IDLE) || !empty || w_enable;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: a clear waits for queued CPU writes before filling.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (clear_start) state_next = WAIT_DRAIN;
      WAIT_DRAIN: if (empty) state_next = CLEAR;
      CLEAR:      if (clr_wr && (clr_cnt == CLR_LAST)) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Per-state control: CPU accept, FIFO drain and clear writes.
  always_comb begin
    req_ready = 1'b0;
    pop       = 1'b0;
    clr_wr    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst && !full;
        pop       = allow && !empty;
      end
      WAIT_DRAIN: pop = allow && !empty;
      CLEAR:      clr_wr = allow;
      default: ;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= req_address;
      mem_data[wr_ptr] <= req_data;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Fill value capture and clear progress counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill    <= '0;
      clr_cnt <= '0;
    end else begin
      if (state == IDLE && clear_start) fill <= clear_data;
      if (state == WAIT_DRAIN)          clr_cnt <= '0;
      else if (clr_wr)                  clr_cnt <= (clr_cnt == CLR_LAST) ? '0 : clr_cnt + CLR_W'(1);
    end
  end

  // Registered VRAM write port; address and data hold between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_enable  <= 1'b0;
      w_address <= '0;
      w_data    <= '0;
    end else begin
      w_enable <= pop || clr_wr;
      if (pop) begin
        w_address <= mem_addr[rd_ptr];
        w_data    <= mem_data[rd_ptr];
      end else if (clr_wr) begin
        w_address <= clr_addr;
        w_data    <= fill;
      end
    end
  end

endmodule

// File: tb/tb_vram_writer.sv
// tb/tb_vram_writer.sv - scoreboard bench for vram_writer
module tb_vram_writer;

  typedef struct packed {
    logic [19:0] a;
    logic [15:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [19:0] req_address = '0;
  logic [15:0] req_data = '0;
  logic        clear_start = 1'b0;
  logic [15:0] clear_data = '0;
  logic        video_enable = 1'b0;
  logic        req_ready, w_enable, busy;
  logic [19:0] w_address;
  logic [15:0] w_data;
  logic [3:0]  fifo_count;

  logic        req_valid_w = 1'b0;
  logic [19:0] req_address_w = '0;
  logic [15:0] req_data_w = '0;
  logic        clear_start_w = 1'b0;
  logic [15:0] clear_data_w = '0;
  logic        req_ready_w, w_enable_w, busy_w;
  logic [19:0] w_address_w;
  logic [15:0] w_data_w;
  logic [2:0]  fifo_count_w;

  ent_t sb[$];
  ent_t sbw[$];
  int   n_cmp = 0;
  int   n_err = 0;

  vram_writer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_address(req_address), .req_data(req_data), .clear_start(clear_start),
    .clear_data(clear_data), .video_enable(video_enable), .w_enable(w_enable),
    .w_address(w_address), .w_data(w_data), .fifo_count(fifo_count), .busy(busy)
  );

  vram_writer #(.FIFO_DEPTH(4), .CLEAR_BASE(20'hFFFFE), .CLEAR_LEN(4), .BLANK_ONLY(0)) dut_w (
    .clk(clk), .rst(rst), .req_valid(req_valid_w), .req_ready(req_ready_w),
    .req_address(req_address_w), .req_data(req_data_w), .clear_start(clear_start_w),
    .clear_data(clear_data_w), .video_enable(video_enable), .w_enable(w_enable_w),
    .w_address(w_address_w), .w_data(w_data_w), .fifo_count(fifo_count_w), .busy(busy_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 ns later and retire any VRAM write against the scoreboards.
  task automatic tick();
    ent_t e;
    @(posedge clk);
    #1;
    if (w_enable) begin
      check("write_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("w_address", w_address, e.a);
        check("w_data", w_data, e.d);
      end
    end
    if (w_enable_w) begin
      check("wrap_write_expected", sbw.size() != 0, 1);
      if (sbw.size() != 0) begin
        e = sbw.pop_front();
        check("wrap_w_address", w_address_w, e.a);
        check("wrap_w_data", w_data_w, e.d);
      end
    end
  endtask

  initial begin
    int rr_bad;
    int pause_bad;
    logic v;

    // Reset state
    #1;
    check("rst_w_enable", w_enable, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_w_address", w_address, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", req_ready, 1);

    // Single write with two-cycle latency
    req_valid = 1'b1; req_address = 20'h00010; req_data = 16'h1F41;
    sb.push_back('{a: 20'h00010, d: 16'h1F41});
    tick();
    req_valid = 1'b0;
    check("t1_count_after_accept", fifo_count, 1);
    check("t1_no_write_yet", w_enable, 0);
    tick();
    check("t1_write_strobe", w_enable, 1);
    check("t1_busy_during", busy, 1);
    tick();
    check("t1_write_one_cycle", w_enable, 0);
    check("t1_busy_low", busy, 0);

    // Blanking stall: 8 fill the FIFO, the 9th waits
    video_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_address = 20'h00100 + 20'(i); req_data = 16'h2200 + 16'(i);
      check("t2_ready_before_full", req_ready, 1);
      sb.push_back('{a: req_address, d: req_data});
      tick();
    end
    req_address = 20'h00108; req_data = 16'h2208;
    check("t2_ready_full", req_ready, 0);
    check("t2_count_full", fifo_count, 8);
    tick();
    tick();
    check("t2_stalled_no_write", w_enable, 0);
    check("t2_still_full", fifo_count, 8);
    sb.push_back('{a: 20'h00108, d: 16'h2208});
    video_enable = 1'b0;
    tick();
    check("t2_drain_0", w_enable, 1);
    check("t2_ready_after_pop", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("t2_drain_1", w_enable, 1);
    check("t2_count_push_pop", fifo_count, 7);
    for (int i = 2; i < 9; i++) begin
      tick();
      check($sformatf("t2_drain_%0d", i), w_enable, 1);
    end
    tick();
    check("t2_end_no_write", w_enable, 0);
    check("t2_end_busy", busy, 0);
    check("t2_sb_empty", sb.size(), 0);

    // Screen clear with video toggling
    clear_start = 1'b1; clear_data = 16'h0720;
    for (int i = 0; i < 2000; i++) sb.push_back('{a: 20'(i), d: 16'h0720});
    tick();
    clear_start = 1'b0;
    check("t3_ready_low_at_start", req_ready, 0);
    check("t3_busy_at_start", busy, 1);
    rr_bad = 0;
    pause_bad = 0;
    for (int c = 0; c < 4000 && sb.size() != 0; c++) begin
      v = video_enable;
      tick();
      if (v && w_enable) pause_bad++;
      if (sb.size() != 0 && req_ready) rr_bad++;
      video_enable = ((c % 37) < 9);
    end
    video_enable = 1'b0;
    check("t3_clear_complete", sb.size(), 0);
    check("t3_no_write_while_video", pause_bad, 0);
    check("t3_req_ready_low", rr_bad, 0);
    tick();
    check("t3_busy_low", busy, 0);
    check("t3_ready_back", req_ready, 1);

    // Ordering: A, then B accepted with clear_start, then the clear
    req_valid = 1'b1; req_address = 20'h00005; req_data = 16'h1141;
    sb.push_back('{a: 20'h00005, d: 16'h1141});
    tick();
    req_address = 20'h00006; req_data = 16'h1142;
    check("t4_ready_for_b", req_ready, 1);
    clear_start = 1'b1; clear_data = 16'h1234;
    sb.push_back('{a: 20'h00006, d: 16'h1142});
    for (int i = 0; i < 2000; i++) sb.push_back('{a: 20'(i), d: 16'h1234});
    tick();
    req_valid = 1'b0; clear_start = 1'b0;
    check("t4_ready_low_wait_drain", req_ready, 0);
    for (int c = 0; c < 2500 && sb.size() != 0; c++) tick();
    check("t4_sequence_complete", sb.size(), 0);
    tick();
    check("t4_busy_low", busy, 0);

    // Wrap-around clear on the second instance, writes allowed during video
    video_enable = 1'b1;
    clear_start_w = 1'b1; clear_data_w = 16'h0F20;
    sbw.push_back('{a: 20'hFFFFE, d: 16'h0F20});
    sbw.push_back('{a: 20'hFFFFF, d: 16'h0F20});
    sbw.push_back('{a: 20'h00000, d: 16'h0F20});
    sbw.push_back('{a: 20'h00001, d: 16'h0F20});
    tick();
    clear_start_w = 1'b0;
    for (int c = 0; c < 20 && sbw.size() != 0; c++) tick();
    check("t5_wrap_complete", sbw.size(), 0);
    tick();
    check("t5_wrap_busy_low", busy_w, 0);
    check("t5_wrap_ready", req_ready_w, 1);
    video_enable = 1'b0;

    // Reset in the middle of a clear
    clear_start = 1'b1; clear_data = 16'h0A41;
    for (int i = 0; i < 100; i++) sb.push_back('{a: 20'(i), d: 16'h0A41});
    tick();
    clear_start = 1'b0;
    for (int c = 0; c < 500 && sb.size() != 0; c++) tick();
    check("t6_hundred_writes", sb.size(), 0);
    check("t6_write_100_visible", w_enable, 1);
    rst = 1'b1;
    #1;
    check("t6_async_w_enable", w_enable, 0);
    check("t6_async_fifo_count", fifo_count, 0);
    check("t6_async_ready", req_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check("t6_idle_after_reset", busy, 0);
    check("t6_no_writes_after_reset", w_enable, 0);
    req_valid = 1'b1; req_address = 20'h00300; req_data = 16'h5A5A;
    sb.push_back('{a: 20'h00300, d: 16'h5A5A});
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 5 && sb.size() != 0; c++) tick();
    check("t6_new_request_served", sb.size(), 0);
    tick();
    check("t6_final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vram_writer.md
Name: vram_writer

Overview:
- Write-side port for VRAM, the counterpart of the VGA read path. The VGA read path fetches text cells; this block puts them there.
- Accepts CPU cell writes (lower byte glyph, upper byte fg/bg colour) through a valid/ready handshake and buffers them in a FIFO.
- Drains writes into the VRAM write port (w_enable/w_address/w_data), one per cycle, only when writing is permitted.
- Also provides a hardware screen-clear that fills a VRAM range with one cell value.

Parameters:
- ADDR_WIDTH, 20, VRAM address width.
- DATA_WIDTH, 16, cell width (lower byte char, upper byte colour).
- FIFO_DEPTH, 8, write buffer entries; power of two, >= 2.
- CLEAR_BASE, 0, first address filled by clear.
- CLEAR_LEN, 2000, cells filled by clear (80x25 text); >= 1.
- BLANK_ONLY, 1, 1 = drain only while video_enable==0; 0 = drain any cycle.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  CPU write request valid.
- req_ready  out  1  block can accept a request this cycle.
- req_address  in  ADDR_WIDTH  target VRAM address.
- req_data  in  DATA_WIDTH  cell value.
- clear_start  in  1  single-cycle pulse: request a screen clear.
- clear_data  in  DATA_WIDTH  fill value, sampled together with clear_start.
- video_enable  in  1  from VGA controller; 1 = active display.
- w_enable  out  1  VRAM write strobe.
- w_address  out  ADDR_WIDTH  VRAM write address.
- w_data  out  DATA_WIDTH  VRAM write data.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.
- busy  out  1  state!=IDLE or fifo_count!=0 or w_enable.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, FIFO emptied, clear counter=0.
  - w_enable=0, w_address=0, w_data=0, fifo_count=0, busy=0, req_ready=0 while rst is high.
  - Reset mid-drain or mid-clear discards all pending work; no write is issued after release until a new request arrives.
- Write permission: allow = (BLANK_ONLY==0) | (video_enable==0).
- Handshake:
  - A request is accepted on a rising edge when req_valid & req_ready.
  - req_ready = (state==IDLE) & (fifo_count != FIFO_DEPTH). It does not depend on a same-cycle pop.
  - req_valid while req_ready==0 is neither accepted nor lost. The CPU holds it.
- FIFO:
  - Push on accept; pop when allow & not empty & state!=CLEAR.
  - Push and pop in the same cycle leaves the count unchanged.
  - Entries drain in strict acceptance order.
- Output register:
  - All w_* outputs are registered.
  - On a pop edge, w_enable<=1 and w_address/w_data<=head entry. Otherwise w_enable<=0 and w_address/w_data hold.
  - Latency: request accepted at edge k → w_enable high during the cycle after edge k+1 (min 2 cycles), if allow is true.
  - Throughput: one write per cycle while allow holds.
  - allow falling stops pops at the next edge. A write already registered still completes its cycle.
- State machine:
  - IDLE:
    - clear_start=1 → capture clear_data into fill register → WAIT_DRAIN.
    - A request accepted on the same edge as clear_start is pushed first and therefore precedes the clear.
  - WAIT_DRAIN:
    - req_ready=0; FIFO keeps draining.
    - When fifo_count==0 → CLEAR with counter=0.
  - CLEAR:
    - On each allow edge: w_enable<=1, w_address<=(CLEAR_BASE+counter) mod 2^ADDR_WIDTH, w_data<=fill, counter++.
    - After the write with counter==CLEAR_LEN-1 → IDLE.
    - No write on edges where allow==0; the counter holds.
  - clear_start outside IDLE is ignored (not queued).
- Address arithmetic is modulo 2^ADDR_WIDTH. A clear range crossing the top wraps to 0.

Test Plan:
1. Single write: video_enable=0; request addr 0x00010 data 0x1F41 accepted at edge k → w_enable=1 with w_address=0x00010, w_data=0x1F41 in the cycle after edge k+1, one cycle only; busy falls to 0 the cycle after.
2. Blanking stall: video_enable=1, BLANK_ONLY=1; offer 9 back-to-back requests → 8 accepted, req_ready=0, fifo_count=8, w_enable stays 0. Drop video_enable → 8 consecutive writes in order; 9th then accepted.
3. Clear: clear_start with clear_data=0x0720, video_enable=0 → exactly 2000 writes at addresses 0..1999 of 0x0720, req_ready=0 throughout, then busy=0. Toggling video_enable during the clear pauses it without skipping addresses.
4. Ordering: 2 requests (A=0x00005/0x1141, B=0x00006/0x1142) with clear_start on B's accept edge → A, then B, then the clear sequence.
5. Wrap: CLEAR_BASE=0xFFFFE, CLEAR_LEN=4 → addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001, then IDLE.
6. Reset mid-clear: assert rst after the 100th clear write → w_enable=0 and fifo_count=0 immediately (asynchronous); after release no writes, busy=0, a new request is served normally.
